// File: rtl/adder_rr_scheduler.sv
// rtl/adder_rr_scheduler.sv - round-robin scheduler sharing one external 32-bit adder
//
// Purpose: accepts one operand set at a time from NREQ requesters (round-robin
// arbitration), drives the shared combinational adder from registered operands,
// captures sum/carry and returns them with the requester ID.
//
// Optional feature macro: ADDER_SCHED_CHAIN_EN (multi-word carry chaining with
// per-requester lock). Undefined: req_last ignored, each op uses its own req_cin.
//
// Ports:
//   clock0, global_resetn        clock, synchronous active-low reset
//   req_valid/req_ready          per-requester handshake, ready is one-hot grant
//   req_a/req_b                  packed operands, requester i at [i*W +: W]
//   req_cin/req_last             per-requester carry-in / last word of a chain
//   add_a/add_b/add_cin          registered operands to the shared adder
//   add_sum/add_cout             result from the shared adder
//   rsp_valid/rsp_ready          response handshake
//   rsp_sum/rsp_cout/rsp_id      captured result and issuing requester
module adder_rr_scheduler #(
  parameter int W    = 32,
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clock0,
  input  logic              global_resetn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_last,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_cin,
  input  logic [W-1:0]      add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic [ID_W-1:0]   rsp_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   r_id;
  logic [W-1:0]      r_add_a;
  logic [W-1:0]      r_add_b;
  logic              r_add_cin;
  logic              r_rsp_valid;
  logic [W-1:0]      r_rsp_sum;
  logic              r_rsp_cout;
  logic [ID_W-1:0]   r_rsp_id;

  logic [NREQ-1:0]   w_elig;
  logic              w_found;
  logic [ID_W-1:0]   w_win;
  logic              w_accept;
  logic              w_cin;

`ifdef ADDER_SCHED_CHAIN_EN
  logic              r_lock;
  logic [ID_W-1:0]   r_lock_id;

  // While a chain is open only its owner may be granted.
  assign w_elig = r_lock ? (req_valid & (NREQ'(1) << r_lock_id)) : req_valid;
  // Chained words take the carry of the previous word, which is still held
  // in the response register since nobody else ran in between.
  assign w_cin  = r_lock ? r_rsp_cout : req_cin[w_win];
`else
  logic              w_unused_last;

  assign w_unused_last = ^req_last;
  assign w_elig        = req_valid;
  assign w_cin         = req_cin[w_win];
`endif

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = (int'(r_last_grant) + 1 + k) % NREQ;
      if (!w_found && w_elig[v_idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(v_idx);
      end
    end
  end

  // Ready is forced low while reset is asserted so nothing handshakes then.
  assign w_accept  = global_resetn && (r_state == S_IDLE) && w_found;
  assign req_ready = w_accept ? (NREQ'(1) << w_win) : '0;

  always_ff @(posedge clock0) begin
    if (!global_resetn) begin
      r_state      <= S_IDLE;
      r_last_grant <= ID_W'(NREQ - 1);
      r_id         <= '0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_add_cin    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_sum    <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_id     <= '0;
`ifdef ADDER_SCHED_CHAIN_EN
      r_lock       <= 1'b0;
      r_lock_id    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_add_a      <= req_a[int'(w_win)*W +: W];
            r_add_b      <= req_b[int'(w_win)*W +: W];
            r_add_cin    <= w_cin;
            r_id         <= w_win;
            r_last_grant <= w_win;
            r_state      <= S_EXEC;
`ifdef ADDER_SCHED_CHAIN_EN
            r_lock       <= !req_last[w_win];
            r_lock_id    <= w_win;
`endif
          end
        end
        S_EXEC: begin
          // Operands have been stable for a full cycle; adder output is settled.
          r_rsp_sum   <= add_sum;
          r_rsp_cout  <= add_cout;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_add_cin;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb/tb_adder_rr_scheduler.sv - directed self-checking bench for adder_rr_scheduler
module tb_adder_rr_scheduler;

  localparam int W    = 32;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clock0 = 1'b0;
  logic              global_resetn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_last;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_cin;
  logic [W-1:0]      add_sum;
  logic              add_cout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [ID_W-1:0]   rsp_id;

  int n_vec  = 0;
  int n_fail = 0;

  // The shared adder the scheduler is attached to.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  adder_rr_scheduler #(.W(W), .NREQ(NREQ), .ID_W(ID_W)) dut (
    .clock0        (clock0),
    .global_resetn (global_resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_cin       (req_cin),
    .req_last      (req_last),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_cin       (add_cin),
    .add_sum       (add_sum),
    .add_cout      (add_cout),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_sum       (rsp_sum),
    .rsp_cout      (rsp_cout),
    .rsp_id        (rsp_id)
  );

  always #5 clock0 = ~clock0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock0);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic last);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
    req_last[i]     = last;
  endtask

  logic [W-1:0] ma [NREQ];
  logic [W-1:0] mb [NREQ];
  logic         mc [NREQ];

  initial begin
    int           exp_id;
    logic [W:0]   exp_res;

    global_resetn = 1'b0;
    req_valid     = '0;
    req_a         = '0;
    req_b         = '0;
    req_cin       = '0;
    req_last      = '0;
    rsp_ready     = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_add_a",     64'(add_a),     64'h0);
    chk("rst_add_b",     64'(add_b),     64'h0);
    chk("rst_add_cin",   64'(add_cin),   64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_sum",   64'(rsp_sum),   64'h0);
    chk("rst_rsp_cout",  64'(rsp_cout),  64'h0);
    chk("rst_rsp_id",    64'(rsp_id),    64'h0);
    global_resetn = 1'b1;
    step();

    // Single op from requester 0
    set_op(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1);
    req_valid = 4'b0001;
    settle();
    chk("single_grant", 64'(req_ready), 64'h1);
    step();
    req_valid = 4'b0000;
    chk("single_exec_valid", 64'(rsp_valid), 64'h0);
    chk("single_exec_ready", 64'(req_ready), 64'h0);
    chk("single_add_a",      64'(add_a),     64'hAAAA_AAAA);
    chk("single_add_b",      64'(add_b),     64'h5555_5555);
    step();
    chk("single_rsp_valid",  64'(rsp_valid), 64'h1);
    chk("single_rsp_sum",    64'(rsp_sum),   64'hFFFF_FFFF);
    chk("single_rsp_cout",   64'(rsp_cout),  64'h0);
    chk("single_rsp_id",     64'(rsp_id),    64'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("single_consumed",   64'(rsp_valid), 64'h0);
    chk("single_add_hold",   64'(add_a),     64'hAAAA_AAAA);

    // Overflow from requester 1
    set_op(1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    req_valid = 4'b0010;
    settle();
    chk("ovf_grant", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'b0000;
    step();
    chk("ovf_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("ovf_rsp_sum",   64'(rsp_sum),   64'h0);
    chk("ovf_rsp_cout",  64'(rsp_cout),  64'h1);
    chk("ovf_rsp_id",    64'(rsp_id),    64'h1);
    rsp_ready = 1'b1;
    step();

    // All requesters valid, 50 random ops; pointer now after requester 1
    for (int i = 0; i < NREQ; i++) begin
      ma[i] = $urandom;
      mb[i] = $urandom;
      mc[i] = 1'($urandom_range(0, 1));
      set_op(i, ma[i], mb[i], mc[i], 1'b1);
    end
    req_valid = 4'b1111;
    settle();
    exp_id = 2;
    for (int n = 0; n < 50; n++) begin
      chk("rr_grant", 64'(req_ready), 64'(4'b0001 << exp_id));
      exp_res = {1'b0, ma[exp_id]} + {1'b0, mb[exp_id]} + {{W{1'b0}}, mc[exp_id]};
      step();
      ma[exp_id] = $urandom;
      mb[exp_id] = $urandom;
      mc[exp_id] = 1'($urandom_range(0, 1));
      set_op(exp_id, ma[exp_id], mb[exp_id], mc[exp_id], 1'b1);
      step();
      chk("rr_rsp_valid", 64'(rsp_valid), 64'h1);
      chk("rr_rsp_id",    64'(rsp_id),    64'(exp_id));
      chk("rr_rsp_res",   64'({rsp_cout, rsp_sum}), 64'(exp_res));
      step();
      exp_id = (exp_id + 1) % NREQ;
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    step();

    // Backpressure; last grant was requester 3, so requester 0 goes first
    set_op(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1);
    set_op(2, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    req_valid = 4'b0101;
    settle();
    chk("bp_grant0", 64'(req_ready), 64'h1);
    step();
    req_valid = 4'b0100;
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_valid", 64'(rsp_valid), 64'h1);
      chk("bp_hold_res",   64'({rsp_cout, rsp_sum}), 64'h0_2345_678A);
      chk("bp_hold_id",    64'(rsp_id),    64'h0);
      chk("bp_hold_ready", 64'(req_ready), 64'h0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_released",   64'(rsp_valid), 64'h0);
    chk("bp_next_grant", 64'(req_ready), 64'h4);
    step();
    req_valid = 4'b0000;
    step();
    chk("bp2_res", 64'({rsp_cout, rsp_sum}), 64'h1_0000_0000);
    chk("bp2_id",  64'(rsp_id),              64'h2);
    step();

    // Reset while requester 1 is in EXEC
    set_op(1, 32'h7, 32'h8, 1'b0, 1'b1);
    req_valid = 4'b0010;
    settle();
    chk("rex_grant", 64'(req_ready), 64'h2);
    step();
    global_resetn = 1'b0;
    step();
    chk("rex_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rex_add_a",     64'(add_a),     64'h0);
    chk("rex_add_b",     64'(add_b),     64'h0);
    chk("rex_rsp_sum",   64'(rsp_sum),   64'h0);
    chk("rex_rsp_id",    64'(rsp_id),    64'h0);
    chk("rex_req_ready", 64'(req_ready), 64'h0);
    global_resetn = 1'b1;
    req_valid     = 4'b0000;
    step();
    step();
    chk("rex_no_rsp", 64'(rsp_valid), 64'h0);
    set_op(0, 32'h3, 32'h4, 1'b1, 1'b1);
    set_op(2, 32'h5, 32'h6, 1'b0, 1'b1);
    req_valid = 4'b0101;
    settle();
    chk("rex_next_grant", 64'(req_ready), 64'h1);
    step();
    req_valid = 4'b0000;
    step();
    chk("rex2_res", 64'({rsp_cout, rsp_sum}), 64'h0_0000_0008);
    chk("rex2_id",  64'(rsp_id),              64'h0);
    step();

`ifdef ADDER_SCHED_CHAIN_EN
    // Two-word chain from requester 1 with requester 2 contending
    set_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    req_valid = 4'b0110;
    settle();
    chk("chain_lo_grant", 64'(req_ready), 64'h2);
    step();
    set_op(1, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk("chain_lo_res", 64'({rsp_cout, rsp_sum}), 64'h1_0000_0000);
    step();
    chk("chain_hi_grant", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'b0100;
    step();
    chk("chain_hi_res", 64'({rsp_cout, rsp_sum}), 64'h0_0000_0001);
    chk("chain_hi_id",  64'(rsp_id),              64'h1);
    step();
    chk("chain_rel_grant", 64'(req_ready), 64'h4);
    step();
    req_valid = 4'b0000;
    step();
    chk("chain_r2_res", 64'({rsp_cout, rsp_sum}), 64'h0_0000_000B);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
